// File: rtl/alu_wb_pkg.sv
// Shared constants and record types for the ALU write-back stage.
// The entry record gives the default write-back entry shape.
package alu_wb_pkg;

   localparam int WB_DEPTH = 2;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   localparam int WB_WIDTH = 32;
   localparam int WB_REGW  = 5;

   typedef struct packed {
      logic [WB_WIDTH-1:0] data;
      logic [WB_REGW-1:0]  addr;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO holding pending register-file writes.
// Only the control state is reset; stored entries are only ever exposed while count is non-zero.
module wb_fifo2
   import alu_wb_pkg::*;
#(
   parameter type entry_t = wb_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  entry_t     din,
   output entry_t     head,
   output logic [1:0] count
);

   localparam logic [1:0] DEPTH_C = 2'(WB_DEPTH);

   logic [1:0] count_q, count_d;
   logic       wptr_q, wptr_d;
   logic       rptr_q, rptr_d;
   entry_t     mem_q [WB_DEPTH];
   entry_t     mem_d [WB_DEPTH];

   logic push_ok;
   logic pop_ok;

   // Guards make an overflowing push or an underflowing pop a no-op.
   assign push_ok = push && (count_q != DEPTH_C);
   assign pop_ok  = pop && (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q ^ push_ok;
      rptr_d  = rptr_q ^ pop_ok;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wptr_q] = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: R0 filter and status-flag register in front of a
// two-entry write buffer feeding the register file.
module alu_wb_stage
   import alu_wb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_zero,
   input  logic             in_neg,
   input  logic             in_over,
   input  logic             in_carry,
   input  logic [REGW-1:0]  in_dest,
   input  logic             in_setflags,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [WIDTH-1:0] wb_data,
   output logic [REGW-1:0]  wb_addr,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_c
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [REGW-1:0]  addr;
   } entry_t;

   logic [3:0] flags_q, flags_d;
   logic [1:0] count;
   entry_t     head;
   entry_t     din;
   logic       accept;
   logic       fifo_push;
   logic       fifo_pop;

   // Ready and valid come only from the registered count, so there is no
   // combinational path between the ALU side and the register-file side.
   assign in_ready  = (count != 2'(WB_DEPTH));
   assign wb_valid  = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign fifo_push = accept && (in_dest != '0);
   assign fifo_pop  = wb_valid && wb_ready;

   assign din.data = in_result;
   assign din.addr = in_dest;

   wb_fifo2 #(
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign wb_data = wb_valid ? head.data : '0;
   assign wb_addr = wb_valid ? head.addr : '0;

   // Flags follow every accepted result with setflags, including R0 writes.
   always_comb begin
      flags_d = flags_q;
      if (accept && in_setflags) begin
         flags_d[FLAG_Z] = in_zero;
         flags_d[FLAG_N] = in_neg;
         flags_d[FLAG_V] = in_over;
         flags_d[FLAG_C] = in_carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flag_z = flags_q[FLAG_Z];
   assign flag_n = flags_q[FLAG_N];
   assign flag_v = flags_q[FLAG_V];
   assign flag_c = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed vector table, asynchronous reset cases,
// and randomized traffic against a queue-based reference model.
module tb_alu_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic        in_zero, in_neg, in_over, in_carry;
   logic [4:0]  in_dest;
   logic        in_setflags;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic        flag_z, flag_n, flag_v, flag_c;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   alu_wb_stage #(.WIDTH(32), .REGW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_zero     (in_zero),
      .in_neg      (in_neg),
      .in_over     (in_over),
      .in_carry    (in_carry),
      .in_dest     (in_dest),
      .in_setflags (in_setflags),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_data     (wb_data),
      .wb_addr     (wb_addr),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_v      (flag_v),
      .flag_c      (flag_c)
   );

   typedef struct {
      bit          iv;
      logic [31:0] res;
      logic [4:0]  dest;
      bit          sf;
      logic [3:0]  fl;      // {z,n,v,c}
      bit          wr;
      bit          e_ir;
      bit          e_wv;
      logic [31:0] e_data;
      logic [4:0]  e_addr;
      logic [3:0]  e_flags;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  a;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] mflags;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit iv, input logic [31:0] res, input logic [4:0] dest,
                        input bit sf, input logic [3:0] fl, input bit wr);
      in_valid    = iv;
      in_result   = res;
      in_dest     = dest;
      in_setflags = sf;
      {in_zero, in_neg, in_over, in_carry} = fl;
      wb_ready    = wr;
   endtask

   function automatic logic [3:0] dut_flags();
      return {flag_z, flag_n, flag_v, flag_c};
   endfunction

   // Reference behaviour for the edge about to happen: drain the head if the
   // register file takes it, then append the accepted non-R0 result.
   task automatic model_step();
      bit acc;
      bit pop;
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() != 0) && wb_ready;
      if (pop) void'(mq.pop_front());
      if (acc && in_dest != 5'd0) mq.push_back('{in_result, in_dest});
      if (acc && in_setflags) mflags = {in_zero, in_neg, in_over, in_carry};
   endtask

   task automatic model_reset();
      mq.delete();
      mflags = 4'b0000;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(mq.size() != 0));
      chk({tag, ".wb_data"}, wb_data, (mq.size() != 0) ? mq[0].d : 32'h0);
      chk({tag, ".wb_addr"}, 32'(wb_addr), (mq.size() != 0) ? 32'(mq[0].a) : 32'h0);
      chk({tag, ".flags"}, 32'(dut_flags()), 32'(mflags));
   endtask

   task automatic finish_cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{1, 32'h0000_00A5, 5'd3, 1, 4'b0000, 1, 1, 0, 32'h0,  5'd0, 4'b0000};
      tbl[1]  = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 1, 1, 32'hA5, 5'd3, 4'b0000};
      tbl[2]  = '{1, 32'h11,        5'd1, 0, 4'b0000, 0, 1, 0, 32'h0,  5'd0, 4'b0000};
      tbl[3]  = '{1, 32'h22,        5'd2, 0, 4'b0000, 0, 1, 1, 32'h11, 5'd1, 4'b0000};
      tbl[4]  = '{1, 32'h33,        5'd4, 1, 4'b1111, 0, 0, 1, 32'h11, 5'd1, 4'b0000};
      tbl[5]  = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 0, 1, 32'h11, 5'd1, 4'b0000};
      tbl[6]  = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 1, 1, 32'h22, 5'd2, 4'b0000};
      tbl[7]  = '{1, 32'h0,         5'd0, 1, 4'b1000, 1, 1, 0, 32'h0,  5'd0, 4'b0000};
      tbl[8]  = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 1, 0, 32'h0,  5'd0, 4'b1000};
      tbl[9]  = '{1, 32'h44,        5'd5, 0, 4'b0000, 0, 1, 0, 32'h0,  5'd0, 4'b1000};
      tbl[10] = '{1, 32'h55,        5'd6, 1, 4'b0101, 1, 1, 1, 32'h44, 5'd5, 4'b1000};
      tbl[11] = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 1, 1, 32'h55, 5'd6, 4'b0101};
      tbl[12] = '{0, 32'h0,         5'd0, 0, 4'b0000, 1, 1, 0, 32'h0,  5'd0, 4'b0101};

      rst_n = 1'b0;
      drive(0, 32'h0, 5'd0, 0, 4'b0000, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst_n = 1'b1;

      // Directed table; row 0 pushes on the first edge after release.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].iv, tbl[i].res, tbl[i].dest, tbl[i].sf, tbl[i].fl, tbl[i].wr);
         #2;
         chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("row%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wv));
         chk($sformatf("row%0d.wb_data", i), wb_data, tbl[i].e_data);
         chk($sformatf("row%0d.wb_addr", i), 32'(wb_addr), 32'(tbl[i].e_addr));
         chk($sformatf("row%0d.flags", i), 32'(dut_flags()), 32'(tbl[i].e_flags));
         finish_cycle();
      end

      // Mid-cycle asynchronous reset with two writes buffered and flags set.
      drive(1, 32'h66, 5'd7, 1, 4'b1111, 0);
      #2;
      check_model("fill1");
      finish_cycle();
      drive(1, 32'h77, 5'd8, 0, 4'b0000, 0);
      #2;
      check_model("fill2");
      finish_cycle();
      drive(0, 32'h0, 5'd0, 0, 4'b0000, 0);
      #2;
      check_model("full");
      rst_n = 1'b0;
      model_reset();
      #1;
      check_model("async_rst");
      @(posedge clk);
      #1;
      check_model("in_rst");
      rst_n = 1'b1;
      drive(0, 32'h0, 5'd0, 0, 4'b0000, 1);
      for (int i = 0; i < 3; i++) begin
         #2;
         check_model($sformatf("post_rst%0d", i));
         finish_cycle();
      end

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, $urandom,
               (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
               $urandom % 2, 4'($urandom), ($urandom % 3) != 0);
         #2;
         check_model("rand");
         if (($urandom % 60) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_model("rand_rst");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else begin
            finish_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
